// File: rtl/sr_encode.sv
// sr_encode: RV32I field-to-instruction encoder with range checking, feeding a
// 2-entry output FIFO that tags each emitted word with its address and counts errors.
module sr_encode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  cmdOp,
    input  logic [4:0]  rd,
    input  logic [2:0]  cmdF3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  cmdF7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_cnt
);
    logic [31:0]      enc;
    logic             enc_err;
    logic             fits12, fits13, fits21;
    logic [1:0][32:0] mem_q, mem_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             rdy_q;
    logic [31:0]      addr_q;
    logic [7:0]       ecnt_q;
    logic             push, pop, wsel;
    // Signed range checks: the bits above the field must all equal the sign bit.
    assign fits12 = imm[31:11] == {21{imm[31]}};
    assign fits13 = imm[31:12] == {20{imm[31]}};
    assign fits21 = imm[31:20] == {12{imm[31]}};
    always_comb begin
        enc     = 32'h0;
        enc_err = 1'b0;
        case (fmt)
            3'd0: enc = {cmdF7, rs2, rs1, cmdF3, rd, cmdOp};
            3'd1: begin
                enc     = {imm[11:0], rs1, cmdF3, rd, cmdOp};
                enc_err = !fits12;
            end
            3'd2: begin
                enc     = {imm[11:5], rs2, rs1, cmdF3, imm[4:0], cmdOp};
                enc_err = !fits12;
            end
            3'd3: begin
                enc     = {imm[12], imm[10:5], rs2, rs1, cmdF3, imm[4:1], imm[11], cmdOp};
                enc_err = !fits13 || imm[0];
            end
            3'd4: begin
                enc     = {imm[31:12], rd, cmdOp};
                enc_err = imm[11:0] != 12'h0;
            end
            3'd5: begin
                enc     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, cmdOp};
                enc_err = !fits21 || imm[0];
            end
            default: enc_err = 1'b1;
        endcase
    end
    assign push = in_valid && rdy_q;
    assign pop  = (cnt_q != 2'd0) && out_ready;
    // A push lands behind whatever survives this cycle's pop.
    assign wsel = cnt_q[0] && !pop;
    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    always_comb begin
        mem_d = mem_q;
        if (pop) mem_d[0] = mem_q[1];
        if (push) mem_d[wsel] = {enc_err, enc};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b0;
            addr_q <= BASE_ADDR;
            ecnt_q <= 8'd0;
        end else begin
            mem_q  <= mem_d;
            cnt_q  <= cnt_d;
            rdy_q  <= !cnt_d[1];
            addr_q <= pop ? addr_q + 32'd4 : addr_q;
            ecnt_q <= (pop && mem_q[0][32] && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
        end
    end
    assign in_ready  = rdy_q;
    assign out_valid = cnt_q != 2'd0;
    assign out_instr = out_valid ? mem_q[0][31:0] : 32'h0;
    assign out_err   = out_valid && mem_q[0][32];
    assign out_addr  = addr_q;
    assign err_cnt   = ecnt_q;
endmodule

// File: doc/sr_encode.md
SR_ENCODE -- requirements
Module: sr_encode

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, meaning the address tagged on the first emitted word after reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  an encode request is present on the field inputs.
REQ-005 in_ready  output  1  the block can accept a request this cycle.
REQ-006 fmt  input  3  instruction format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-007 cmdOp  input  7  opcode field.
REQ-008 rd  input  5  destination register field.
REQ-009 cmdF3  input  3  funct3 field.
REQ-010 rs1  input  5  source register 1 field.
REQ-011 rs2  input  5  source register 2 field.
REQ-012 cmdF7  input  7  funct7 field.
REQ-013 imm  input  32  byte-offset / value immediate, two's complement.
REQ-014 out_valid  output  1  an encoded word is available at the output.
REQ-015 out_ready  input  1  the consumer takes the word this cycle.
REQ-016 out_instr  output  32  encoded RV32I instruction word.
REQ-017 out_addr  output  32  instruction address tag of the current output word.
REQ-018 out_err  output  1  the current output word failed its immediate range check or used an illegal fmt.
REQ-019 err_cnt  output  8  saturating count of emitted words that had out_err=1.

Function
REQ-020 A request is accepted when in_valid=1 and in_ready=1 in the same cycle; an output word is consumed when out_valid=1 and out_ready=1 in the same cycle.
REQ-021 Encoding is combinational from the inputs; the encoded word and its error flag are written into a 2-entry output FIFO on acceptance.
REQ-022 A word accepted at edge N is presented with out_valid=1 after edge N when the FIFO was empty, for a latency of 1 cycle.
REQ-023 in_ready=1 exactly when the FIFO holds fewer than 2 entries; in_ready does not depend combinationally on out_ready.
REQ-024 Full (2 entries) with a simultaneous pop: no push that cycle; the count becomes 1.
REQ-025 Push and pop in the same cycle with 1 entry: the count stays 1 and FIFO order is preserved.
REQ-026 Empty: out_valid=0, out_instr=0 and out_err=0.
REQ-027 Bits [6:0]=cmdOp for every legal format.
REQ-028 R format: rd→[11:7], cmdF3→[14:12], rs1→[19:15], rs2→[24:20], cmdF7→[31:25].
REQ-029 I format: rd, cmdF3 and rs1 as in R; imm[11:0]→[31:20].
REQ-030 S format: imm[4:0]→[11:7], cmdF3, rs1, rs2, imm[11:5]→[31:25].
REQ-031 B format: imm[11]→[7], imm[4:1]→[11:8], cmdF3, rs1, rs2, imm[10:5]→[30:25], imm[12]→[31].
REQ-032 U format: rd, imm[31:12]→[31:12].
REQ-033 J format: rd, imm[19:12]→[19:12], imm[11]→[20], imm[10:1]→[30:21], imm[20]→[31].
REQ-034 Error conditions:
- I or S: imm outside −2048..2047 is an error.
- B: imm outside −4096..4095, or imm[0]=1, is an error.
- U: imm[11:0]≠0 is an error.
- J: imm outside −2^20..2^20−1, or imm[0]=1, is an error.
- R: never an error.
REQ-035 On an error the word is still encoded from the truncated fields and queued with out_err=1.
REQ-036 An illegal fmt queues out_instr=0 with out_err=1.
REQ-037 out_addr starts at BASE_ADDR, increments by 4 on every output handshake, and wraps modulo 2^32.
REQ-038 err_cnt increments on every output handshake whose word has out_err=1, and saturates at 255.

Reset
REQ-039 rst_n=0 asynchronously sets: FIFO empty, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0, in_ready=0.
REQ-040 in_ready stays 0 while rst_n=0 and becomes 1 on the first clock edge after release.
REQ-041 Assertion mid-operation discards all queued words without emitting them.

Verification
REQ-042 I fmt, cmdOp=0x13, rd=1, rs1=0, cmdF3=0, imm=5, out_ready=1 -> next cycle out_instr=0x00500093, out_addr=0, out_err=0.
REQ-043 S fmt, cmdOp=0x23, cmdF3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423; then B fmt, cmdOp=0x63, rs1=0, rs2=0, cmdF3=0, imm=−4 -> 0xFE000EE3 with out_addr=4.
REQ-044 U fmt, cmdOp=0x37, rd=5, imm=0x12345000 -> 0x123452B7; imm=0x12345001 -> out_err=1 and err_cnt=1 after the handshake.
REQ-045 out_ready held 0, three back-to-back requests -> in_ready=0 after 2 accepts; raise out_ready -> words emerge in order with out_addr 0, 4, 8.
REQ-046 Assert rst_n=0 with 2 queued words -> out_valid=0 immediately, out_addr=BASE_ADDR, nothing emitted after release.
